// File: rtl/parity_fifo_pkg.sv
// Shared defaults, stored-word type and the parity helper used by the FIFO and the downstream checker.
package parity_fifo_pkg;

    localparam int    DEF_WIDTH       = 8;
    localparam int    DEF_DEPTH       = 8;
    localparam int    DEF_DATA_WIDTH  = DEF_WIDTH + 1;
    localparam string DEF_PARITY_BIT  = "MSB";
    localparam string DEF_PARITY_TYPE = "EVEN";

    // Widest payload calc_parity accepts; narrower payloads are zero-extended, which leaves parity unchanged.
    localparam int    MAX_WIDTH       = 64;

    typedef logic [DEF_DATA_WIDTH-1:0] fifo_word_t;

    typedef enum logic {
        PAR_EVEN = 1'b0,
        PAR_ODD  = 1'b1
    } parity_type_e;

    function automatic logic calc_parity(input logic [MAX_WIDTH-1:0] payload, input parity_type_e ptype);
        return (ptype == PAR_ODD) ? ~^payload : ^payload;
    endfunction

endpackage

// File: rtl/parity_fifo_parity_gen.sv
// Combinational payload-to-stored-word conversion: computes the parity bit and places it at PARITY_BIT.
module parity_gen
    import parity_fifo_pkg::*;
#(
    parameter int    WIDTH       = DEF_WIDTH,
    parameter string PARITY_BIT  = DEF_PARITY_BIT,
    parameter string PARITY_TYPE = DEF_PARITY_TYPE,
    localparam int   DATA_WIDTH  = WIDTH + 1
) (
    input  logic [WIDTH-1:0]      payload,
    output logic [DATA_WIDTH-1:0] word
);

    localparam parity_type_e PTYPE = (PARITY_TYPE == "ODD") ? PAR_ODD : PAR_EVEN;

    logic [MAX_WIDTH-1:0] payload_ext;
    logic                 parity;

    assign payload_ext = MAX_WIDTH'(payload);
    assign parity      = calc_parity(payload_ext, PTYPE);

    generate
        if (PARITY_BIT == "LSB") begin : g_lsb
            assign word = {payload, parity};
        end else begin : g_msb
            assign word = {parity, payload};
        end
    endgenerate

endmodule

// File: rtl/parity_fifo.sv
// Parity-tagging synchronous FIFO with first-word fall-through read.
// Optional occupancy outputs (count_o, almost_full_o) are built when FIFO_OCCUPANCY_EN is defined.
module parity_fifo
    import parity_fifo_pkg::*;
#(
    parameter int    WIDTH       = DEF_WIDTH,
    parameter int    DEPTH       = DEF_DEPTH,
    parameter string PARITY_BIT  = DEF_PARITY_BIT,
    parameter string PARITY_TYPE = DEF_PARITY_TYPE,
    localparam int   DATA_WIDTH  = WIDTH + 1,
    localparam int   AW          = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      push_data_i,
    input  logic                  push_valid_i,
    output logic                  push_grant_o,
    output logic [DATA_WIDTH-1:0] pop_data_o,
    output logic                  pop_valid_o,
    input  logic                  pop_grant_i
`ifdef FIFO_OCCUPANCY_EN
    ,
    output logic [AW:0]           count_o,
    output logic                  almost_full_o
`endif
);

    // Handshake: a transfer happens on a rising edge where valid and grant are both high; valid may
    // be held while grant is low, and both grants depend only on registered pointers.

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("parity_fifo: DEPTH must be a power of two and >= 2");
        end
        if (PARITY_BIT != "MSB" && PARITY_BIT != "LSB") begin : g_bad_pbit
            $error("parity_fifo: PARITY_BIT must be \"MSB\" or \"LSB\"");
        end
        if (PARITY_TYPE != "EVEN" && PARITY_TYPE != "ODD") begin : g_bad_ptype
            $error("parity_fifo: PARITY_TYPE must be \"EVEN\" or \"ODD\"");
        end
    endgenerate

    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] push_word;
    logic                  empty;
    logic                  full;
    logic                  push_fire;
    logic                  pop_fire;

    parity_gen #(
        .WIDTH       (WIDTH),
        .PARITY_BIT  (PARITY_BIT),
        .PARITY_TYPE (PARITY_TYPE)
    ) u_parity_gen (
        .payload (push_data_i),
        .word    (push_word)
    );

    // Pointer MSB is the wrap bit: same index with differing wrap bits means full.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    assign push_grant_o = !full;
    assign pop_valid_o  = !empty;
    assign push_fire    = push_valid_i && push_grant_o;
    assign pop_fire     = pop_valid_o && pop_grant_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_fire) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_fire) begin
            mem[wr_ptr[AW-1:0]] <= push_word;
        end
    end

    assign pop_data_o = mem[rd_ptr[AW-1:0]];

`ifdef FIFO_OCCUPANCY_EN
    assign count_o       = wr_ptr - rd_ptr;
    assign almost_full_o = (count_o >= (AW+1)'(DEPTH - 1));
`endif

endmodule

// File: tb/tb_parity_fifo.sv
// Self-checking bench for parity_fifo: queue-based reference model plus directed literal checks.
// Occupancy outputs are also checked when FIFO_OCCUPANCY_EN is defined.
module tb_parity_fifo;

    localparam int W     = 8;
    localparam int DEPTH = 4;
    localparam int DW    = W + 1;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst_n;
    logic [W-1:0]  push_data;
    logic          push_valid;
    logic          push_grant;
    logic [DW-1:0] pop_data;
    logic          pop_valid;
    logic          pop_grant;

    logic [W-1:0]  o_push_data;
    logic          o_push_valid;
    logic          o_push_grant;
    logic [DW-1:0] o_pop_data;
    logic          o_pop_valid;
    logic          o_pop_grant;

`ifdef FIFO_OCCUPANCY_EN
    logic [CW-1:0] count;
    logic          almost_full;
    logic [CW-1:0] o_count;
    logic          o_almost_full;
`endif

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] exp_q[$];
    bit            last_push_fire;
    bit            model_en;

    parity_fifo #(.WIDTH(W), .DEPTH(DEPTH), .PARITY_BIT("MSB"), .PARITY_TYPE("EVEN")) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_data_i  (push_data),
        .push_valid_i (push_valid),
        .push_grant_o (push_grant),
        .pop_data_o   (pop_data),
        .pop_valid_o  (pop_valid),
        .pop_grant_i  (pop_grant)
`ifdef FIFO_OCCUPANCY_EN
        ,
        .count_o       (count),
        .almost_full_o (almost_full)
`endif
    );

    parity_fifo #(.WIDTH(W), .DEPTH(DEPTH), .PARITY_BIT("LSB"), .PARITY_TYPE("ODD")) dut_odd (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_data_i  (o_push_data),
        .push_valid_i (o_push_valid),
        .push_grant_o (o_push_grant),
        .pop_data_o   (o_pop_data),
        .pop_valid_o  (o_pop_valid),
        .pop_grant_i  (o_pop_grant)
`ifdef FIFO_OCCUPANCY_EN
        ,
        .count_o       (o_count),
        .almost_full_o (o_almost_full)
`endif
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Even parity, MSB placement: the parity bit makes the total count of ones even.
    function automatic logic [DW-1:0] exp_word(input logic [W-1:0] d);
        logic p;
        p = ($countones(d) % 2) == 1;
        return {p, d};
    endfunction

    // Reference model: an ordered queue of accepted words, capacity DEPTH.
    always @(posedge clk or negedge rst_n) begin
        bit pf;
        bit pp;
        if (!rst_n) begin
            exp_q.delete();
            last_push_fire = 1'b0;
        end else begin
            pf = push_valid && (exp_q.size() < DEPTH);
            pp = pop_grant && (exp_q.size() > 0);
            if (pp) void'(exp_q.pop_front());
            if (pf) exp_q.push_back(exp_word(push_data));
            last_push_fire = pf;
        end
    end

    // Scoreboard compare on every falling edge while out of reset.
    always @(negedge clk) begin
        if (rst_n && model_en) begin
            check("pop_valid", 32'(pop_valid), 32'(exp_q.size() != 0));
            check("push_grant", 32'(push_grant), 32'(exp_q.size() < DEPTH));
            if (exp_q.size() > 0) begin
                check("pop_data", 32'(pop_data), 32'(exp_q[0]));
                check("pop_parity_even", 32'($countones(pop_data) % 2), 32'd0);
            end
`ifdef FIFO_OCCUPANCY_EN
            check("count", 32'(count), 32'(exp_q.size()));
            check("almost_full", 32'(almost_full), 32'(exp_q.size() >= DEPTH - 1));
`endif
        end
    end

    // Driver: apply inputs at a falling edge, then advance one full cycle.
    task automatic cyc(input bit pv, input logic [W-1:0] pd, input bit pg);
        push_valid = pv;
        push_data  = pd;
        pop_grant  = pg;
        @(negedge clk);
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < bound) begin
            cyc(1'b0, '0, 1'b1);
            n++;
        end
        check("drain_done", 32'(exp_q.size()), 32'd0);
        pop_grant = 1'b0;
    endtask

    initial begin
        int idx;
        int cycles;
        bit pv;

        rst_n        = 1'b0;
        push_valid   = 1'b0;
        push_data    = '0;
        pop_grant    = 1'b0;
        o_push_valid = 1'b0;
        o_push_data  = '0;
        o_pop_grant  = 1'b0;
        model_en     = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_pop_valid", 32'(pop_valid), 32'd0);
        check("reset_push_grant", 32'(push_grant), 32'd1);
        rst_n    = 1'b1;
        model_en = 1'b1;
        @(negedge clk);

        // Two pushes, FIFO order and one-cycle latency
        check("empty_pop_valid", 32'(pop_valid), 32'd0);
        cyc(1'b1, 8'h03, 1'b0);
        check("latency_pop_valid", 32'(pop_valid), 32'd1);
        cyc(1'b1, 8'h07, 1'b0);
        check("first_word", 32'(pop_data), 32'h003);
        cyc(1'b0, '0, 1'b1);
        check("second_word", 32'(pop_data), 32'h107);
        cyc(1'b0, '0, 1'b1);
        check("after_two_pops_empty", 32'(pop_valid), 32'd0);

        // Fill to full, hold a 5th push, then one pop re-grants
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'hA0 + 8'(i), 1'b0);
        check("full_grant_low", 32'(push_grant), 32'd0);
        repeat (3) cyc(1'b1, 8'h5A, 1'b0);
        check("held_push_grant_low", 32'(push_grant), 32'd0);
        check("head_still_first", 32'(pop_data), 32'h0A0);
        cyc(1'b1, 8'h5A, 1'b1);
        check("regrant_after_pop", 32'(push_grant), 32'd1);
        cyc(1'b1, 8'h5A, 1'b0);
        check("refilled_grant_low", 32'(push_grant), 32'd0);
        drain(20);

        // Occupancy 2 with push and pop every cycle
        cyc(1'b1, 8'h11, 1'b0);
        cyc(1'b1, 8'h22, 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b1, 8'($urandom_range(0, 255)), 1'b1);
        check("steady_valid", 32'(pop_valid), 32'd1);
        check("steady_grant", 32'(push_grant), 32'd1);
        drain(20);

        // Random stream of 0x00..0x13
        idx    = 0;
        cycles = 0;
        while ((idx < 20 || exp_q.size() > 0) && cycles < 400) begin
            pv = (idx < 20) && ($urandom_range(0, 3) != 0);
            cyc(pv, 8'(idx), 1'($urandom_range(0, 1)));
            if (last_push_fire) idx++;
            cycles++;
        end
        check("stream_all_pushed", 32'(idx), 32'd20);
        check("stream_drained", 32'(exp_q.size()), 32'd0);
        pop_grant = 1'b0;
        @(negedge clk);

        // Asynchronous reset in the middle of a cycle
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'($urandom_range(0, 255)), 1'b0);
        push_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_pop_valid", 32'(pop_valid), 32'd0);
        check("async_rst_push_grant", 32'(push_grant), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_empty", 32'(pop_valid), 32'd0);
        check("post_rst_grant", 32'(push_grant), 32'd1);

        // ODD parity, LSB placement instance
        o_push_valid = 1'b1;
        o_push_data  = 8'h00;
        @(negedge clk);
        o_push_data  = 8'h01;
        @(negedge clk);
        o_push_valid = 1'b0;
        check("odd_lsb_valid", 32'(o_pop_valid), 32'd1);
        check("odd_lsb_word0", 32'(o_pop_data), 32'h001);
        o_pop_grant = 1'b1;
        @(negedge clk);
        check("odd_lsb_word1", 32'(o_pop_data), 32'h002);
        @(negedge clk);
        o_pop_grant = 1'b0;
        check("odd_lsb_empty", 32'(o_pop_valid), 32'd0);
        check("odd_lsb_grant", 32'(o_push_grant), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
